stack_pointer_unit: RTL
=======================

# stack_pointer_unit

Owns and updates the 16-bit stack pointer; executes push, pop, adjust and load requests from the control unit, and drives the data-memory port for stack traffic. It is the producer of the `SP` value that downstream address-segment logic reads. Every request gets exactly one response pulse. Bounds violations are reported, not executed.

## Interface
Parameters:
- `WIDTH`, 16: data, address and SP width.
- `STACK_TOP`, 16'h0400: empty-stack SP value, which is also the reset value.
- `STACK_LIMIT`, 16'h0000: lowest legal SP value, meaning the stack is full.
- `STEP`, 2: bytes per stack word.

Ports:
- `CLK` in 1: single clock, rising edge.
- `Reset_n` in 1: synchronous, active-low reset.
- `op_valid` in 1: request present.
- `op_ready` out 1: unit can accept a request.
- `op_code` in 2: 00 push, 01 pop, 10 adjust (SP += signed `op_data`), 11 load (SP = `op_data`).
- `op_data` in WIDTH: push data, adjust amount or new SP.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out WIDTH: popped word. 0 for all other ops and on error.
- `rsp_err` out 1: bounds or alignment violation. Valid with `rsp_valid`.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out WIDTH, `mem_wdata` out WIDTH: memory request.
- `mem_rdata` in WIDTH, `mem_ack` in 1: memory completion.
- `SP` out WIDTH: current stack pointer, registered.

## Operation
- States:
  - IDLE: `op_ready`=1.
  - WRITE: push memory phase.
  - READ: pop memory phase.
  - DONE: response cycle, `op_ready`=0.
- Accept occurs on the rising edge where `op_valid`&`op_ready`. `op_code` and `op_data` are latched at that edge.
- Push:
  - Legal if `SP` ≥ `STACK_LIMIT`+`STEP`. The check uses a 17-bit unsigned difference; a borrow means illegal.
  - Legal path: IDLE→WRITE with `mem_addr`=`SP`−`STEP`, `mem_we`=1, `mem_wdata`=data.
  - On the `mem_ack` edge, `SP`←`SP`−`STEP` and the state goes to DONE.
  - Illegal path: IDLE→DONE with `rsp_err`=1, SP unchanged, no `mem_req`.
- Pop:
  - Legal if `SP` ≤ `STACK_TOP`−`STEP`.
  - Legal path: IDLE→READ with `mem_addr`=`SP`, `mem_we`=0.
  - On the `mem_ack` edge, `rsp_data`←`mem_rdata`, `SP`←`SP`+`STEP`, and the state goes to DONE.
  - Illegal path: DONE with `rsp_err`=1.
- Adjust / load:
  - Compute the candidate SP in 17 bits.
  - Legal if `STACK_LIMIT` ≤ candidate ≤ `STACK_TOP` and candidate[0]=0. Then SP←candidate at the accept edge.
  - Otherwise SP is unchanged and `rsp_err`=1.
  - Both go IDLE→DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, then IDLE.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are held stable from entry to WRITE/READ until the `mem_ack` edge. `mem_req` is 0 in IDLE and DONE.
- `mem_ack` seen in IDLE or DONE is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `SP`=`STACK_TOP`.
  - `op_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_data`=0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Adjust, load and any error: `rsp_valid` rises in the cycle after accept (latency 1). Next accept is possible 2 cycles after the previous accept.
- Push/pop: `mem_req` rises in the cycle after accept. With `mem_ack` at wait n≥0 (ack sampled high in the first `mem_req` cycle means n=0), `rsp_valid` occurs at accept+2+n.
- `SP` changes on exactly one edge per legal op:
  - the accept edge for adjust/load;
  - the `mem_ack` edge for push/pop.
- Reset mid-operation (`Reset_n`=0 at any edge):
  - state→IDLE, `mem_req`→0 and `rsp_valid`→0 at that edge;
  - the pending op is discarded with no response;
  - SP returns to `STACK_TOP`.
- `op_valid` asserted while `op_ready`=0 is not accepted. The requester holds the request.

## Structure
- Package `stack_pkg` holds:
  - op_code localparams (OP_PUSH, OP_POP, OP_ADJ, OP_LOAD);
  - state encoding (S_IDLE, S_WRITE, S_READ, S_DONE);
  - default `STACK_TOP`, `STACK_LIMIT` and `STEP`.
- Sub-module `stack_bounds_check` (combinational): inputs are current SP, op_code and op_data; outputs are candidate SP and `illegal`. Used by the FSM at accept.

## Test plan
- Reset, then push 16'hBEEF with `mem_ack` after 2 waits → `mem_addr`=16'h03FE, `mem_we`=1; SP=16'h03FE; `rsp_valid` at accept+4, `rsp_err`=0.
- Pop immediately after the push, `mem_rdata`=16'hBEEF, ack n=0 → `mem_addr`=16'h03FE, `rsp_data`=16'hBEEF, SP=16'h0400.
- Pop on an empty stack (SP=16'h0400) → no `mem_req`; `rsp_err`=1 at accept+1; SP unchanged.
- Load 16'h0002 then push twice → first push succeeds, SP=16'h0000; second push gives `rsp_err`=1 with no memory request.
- Adjust −3 from 16'h0400 → error (odd result). Adjust −16 → SP=16'h03F0 at accept edge, `rsp_valid` at accept+1.
- Assert `Reset_n`=0 during a push's WRITE wait → `mem_req` drops the next edge, no `rsp_valid`, SP=16'h0400; a late `mem_ack` is ignored.

Source files
------------

// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared op codes, FSM encoding and stack geometry defaults
package stack_pkg;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_ADJ  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [15:0] DEF_STACK_TOP   = 16'h0400;
    localparam logic [15:0] DEF_STACK_LIMIT = 16'h0000;
    localparam int unsigned DEF_STEP        = 2;

endpackage

// File: rtl/stack_bounds_check.sv
// rtl/stack_bounds_check.sv - candidate SP and legality for a request at accept
module stack_bounds_check
    import stack_pkg::*;
#(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] STACK_TOP   = DEF_STACK_TOP,
    parameter logic [WIDTH-1:0] STACK_LIMIT = DEF_STACK_LIMIT,
    parameter int unsigned      STEP        = DEF_STEP
) (
    input  logic [WIDTH-1:0] sp,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic [WIDTH-1:0] cand,
    output logic             illegal
);

    localparam logic [WIDTH:0] TOP_X   = {1'b0, STACK_TOP};
    localparam logic [WIDTH:0] LIMIT_X = {1'b0, STACK_LIMIT};
    localparam logic [WIDTH:0] STEP_X  = (WIDTH+1)'(STEP);

    logic [WIDTH:0] sp_x;
    logic [WIDTH:0] cand_x;
    logic [WIDTH:0] diff_x;

    // One extra bit: a borrow (or a negative adjust result) lands in bit WIDTH
    always_comb begin
        sp_x    = {1'b0, sp};
        cand_x  = sp_x;
        diff_x  = '0;
        illegal = 1'b0;
        case (op_code)
            OP_PUSH: begin
                cand_x  = sp_x - STEP_X;
                diff_x  = sp_x - (LIMIT_X + STEP_X);
                illegal = diff_x[WIDTH];
            end
            OP_POP: begin
                cand_x  = sp_x + STEP_X;
                diff_x  = (TOP_X - STEP_X) - sp_x;
                illegal = diff_x[WIDTH];
            end
            default: begin
                if (op_code == OP_ADJ) begin
                    cand_x = sp_x + {op_data[WIDTH-1], op_data};
                end else begin
                    cand_x = {1'b0, op_data};
                end
                illegal = (cand_x < LIMIT_X) || (cand_x > TOP_X) || cand_x[0];
            end
        endcase
        cand = cand_x[WIDTH-1:0];
    end

endmodule

// File: rtl/stack_pointer_unit.sv
// rtl/stack_pointer_unit.sv - stack pointer owner executing push/pop/adjust/load requests
module stack_pointer_unit
    import stack_pkg::*;
#(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] STACK_TOP   = DEF_STACK_TOP,
    parameter logic [WIDTH-1:0] STACK_LIMIT = DEF_STACK_LIMIT,
    parameter int unsigned      STEP        = DEF_STEP
) (
    input  logic             CLK,
    input  logic             Reset_n,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [WIDTH-1:0] SP
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] sp_q, sp_d;
    logic             op_ready_q, op_ready_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic [WIDTH-1:0] cand;
    logic             illegal;
    logic             accept;

    stack_bounds_check #(
        .WIDTH      (WIDTH),
        .STACK_TOP  (STACK_TOP),
        .STACK_LIMIT(STACK_LIMIT),
        .STEP       (STEP)
    ) u_bounds (
        .sp     (sp_q),
        .op_code(op_code),
        .op_data(op_data),
        .cand   (cand),
        .illegal(illegal)
    );

    assign accept = op_valid && op_ready_q;

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            sp_q        <= STACK_TOP;
            op_ready_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            op_ready_q  <= op_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (illegal)                  state_d = S_DONE;
                    else if (op_code == OP_PUSH)  state_d = S_WRITE;
                    else if (op_code == OP_POP)   state_d = S_READ;
                    else                          state_d = S_DONE;
                end
            end
            S_WRITE, S_READ: begin
                if (mem_ack) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so every port is a plain register
    always_comb begin
        sp_d        = sp_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_data_d  = '0;
        rsp_err_d   = 1'b0;
        op_ready_d  = (state_d == S_IDLE);
        rsp_valid_d = (state_d == S_DONE);
        mem_req_d   = (state_d == S_WRITE) || (state_d == S_READ);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        rsp_err_d = 1'b1;
                    end else if (op_code == OP_PUSH) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = cand;
                        mem_wdata_d = op_data;
                    end else if (op_code == OP_POP) begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = sp_q;
                    end else begin
                        sp_d = cand;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ack) sp_d = mem_addr_q;
            end
            S_READ: begin
                if (mem_ack) begin
                    sp_d       = sp_q + WIDTH'(STEP);
                    rsp_data_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign op_ready  = op_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign SP        = sp_q;

endmodule
